vga_timing_streamer: RTL



---
 rtl/vga_timing_streamer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/vga_timing_streamer.sv
// rtl/vga_timing_streamer.sv - VGA sync/blank scan generator fed by a ready/valid RGB pixel stream
//
// Ports:
//   clk, rst_n          pixel clock, synchronous active-low reset
//   pll_locked          PLL lock indication, asynchronous to clk (synchronised here)
//   in_data             pixel beat {R,G,B}, CW bits per channel
//   in_sop              beat is the first pixel of a frame
//   in_valid, in_ready  stream handshake; a beat moves when both are high
//   vga_r/g/b           registered colour, zero outside displayed pixels
//   vga_hs, vga_vs      registered syncs, active-low
//   vga_blank_n         registered, high during the active region
//   vga_sync_n          constant 0
//   underflow           sticky stream error flag, cleared only by reset
module vga_timing_streamer #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CW       = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pll_locked,
    input  logic [3*CW-1:0] in_data,
    input  logic            in_sop,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [CW-1:0]   vga_r,
    output logic [CW-1:0]   vga_g,
    output logic [CW-1:0]   vga_b,
    output logic            vga_hs,
    output logic            vga_vs,
    output logic            vga_blank_n,
    output logic            vga_sync_n,
    output logic            underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS_C   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE_C   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST_C = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS_C   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE_C   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST_C = VW'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEEK,
        RUN
    } state_t;

    state_t        state;
    logic          lock_meta;
    logic          lock_s;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;

    logic active;
    logic at_origin;
    logic h_sync_on;
    logic v_sync_on;
    logic beat;
    logic stray_sop;

    assign active    = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    assign at_origin = (h_cnt == '0) && (v_cnt == '0);
    assign h_sync_on = (h_cnt >= H_SS_C) && (h_cnt < H_SE_C);
    assign v_sync_on = (v_cnt >= V_SS_C) && (v_cnt < V_SE_C);

    // SEEK drains everything except an SOP, which is parked on the bus
    // until the raster reaches the top-left pixel. RUN pulls exactly one
    // beat per visible pixel.
    always_comb begin
        in_ready = 1'b0;
        case (state)
            SEEK:    in_ready = in_valid && (!in_sop || at_origin);
            RUN:     in_ready = active;
            default: in_ready = 1'b0;
        endcase
    end

    assign beat       = in_valid && in_ready;
    assign stray_sop  = beat && in_sop && !at_origin;
    assign vga_sync_n = 1'b0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_meta   <= 1'b0;
            lock_s      <= 1'b0;
            state       <= IDLE;
            h_cnt       <= '0;
            v_cnt       <= '0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;

            if (!lock_s || state == IDLE) begin
                // Raster parked at the origin with idle pins; the first
                // locked cycle only moves to SEEK so counting starts at 0.
                state       <= lock_s ? SEEK : IDLE;
                h_cnt       <= '0;
                v_cnt       <= '0;
                vga_r       <= '0;
                vga_g       <= '0;
                vga_b       <= '0;
                vga_hs      <= 1'b1;
                vga_vs      <= 1'b1;
                vga_blank_n <= 1'b0;
            end else begin
                vga_hs                <= !h_sync_on;
                vga_vs                <= !v_sync_on;
                vga_blank_n           <= active;
                {vga_r, vga_g, vga_b} <= '0;

                if (state == SEEK) begin
                    // An SOP can only be accepted at the origin here.
                    if (beat && in_sop) begin
                        state                 <= RUN;
                        {vga_r, vga_g, vga_b} <= in_data;
                    end
                end else begin
                    if (active && !in_valid) begin
                        underflow <= 1'b1;
                        state     <= SEEK;
                    end else if (stray_sop) begin
                        underflow <= 1'b1;
                        state     <= SEEK;
                    end else if (beat) begin
                        {vga_r, vga_g, vga_b} <= in_data;
                    end
                end

                if (h_cnt == H_LAST_C) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST_C) ? '0 : v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

endmodule
